sim_exit_device: RTL and testbench
==================================

# sim_exit_device

Memory-mapped simulation-control responder on the core's data bus. It is the device the running program writes to, where the bench instead writes into the core's memories. It decodes stores to a small register window and does three things: records a sticky pass/fail exit code (tohost), buffers console bytes into a FIFO drained over a valid/ready byte stream, and raises a cycle-count timeout. The bench watches `done` to end the simulation.

## Interface
Parameters:
- `BASE_ADDR`, 32'h8000_0000: base of the 16-byte register window.
- `CONSOLE_DEPTH`, 16: console FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 100000: cycles after reset until forced timeout; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  core clock.
- `arst`  in  1  asynchronous active-high reset.
- `req_valid`  in  1  bus request present.
- `req_ready`  out  1  request accepted this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables.
- `rsp_valid`  out  1  response for the previously accepted request.
- `rsp_rdata`  out  32  load data; 0 for stores.
- `tx_valid`  out  1  console byte available.
- `tx_data`  out  8  console byte.
- `tx_ready`  in  1  bench/sink takes the byte.
- `done`  out  1  sticky end-of-test.
- `pass`  out  1  `done` with exit code 0 and no timeout.
- `exit_code`  out  31  code written by the program.
- `timed_out`  out  1  `done` was caused by the timeout.

## Operation
- Hit condition: `req_addr[31:4] == BASE_ADDR[31:4]`. Offsets are word-aligned and `req_addr[1:0]` is ignored.
- Offset 0x0, TOHOST. A store with `req_be[0]` set and `wdata[0]=1` sets `done`, latches `exit_code = wdata[31:1]` and clears `timed_out`. A store with `wdata[0]=0` is ignored. A load returns `{exit_code, done}`.
- Offset 0x4, CONSOLE. A store with `req_be[0]` set pushes `wdata[7:0]`. A load returns 0.
- Offset 0x8, STATUS, read-only. Returns `{27'b0, timed_out, count[3:0]}` with `count` saturated at 15.
- Offset 0xC and misses: loads return 0, stores are dropped. Every request still receives a response.
- `done` is sticky until reset. After `done`, TOHOST stores and the timeout have no effect. Console pushes continue.
- Timeout: a free-running cycle counter counts while `!done`. When it reaches `TIMEOUT_CYCLES`, `done=1`, `timed_out=1` and `exit_code` is 31'h7FFF_FFFF.
- `pass = done & !timed_out & (exit_code == 0)`.

## Timing
- `req_ready` is combinational: 0 only for a CONSOLE store while the FIFO is full, otherwise 1. A push never happens while the FIFO is full, even if a pop occurs the same cycle; the push is accepted the following cycle.
- `rsp_valid` pulses exactly one cycle after an accepted request. `rsp_rdata` is registered.
- TOHOST effect: `done` is visible the cycle after acceptance.
- Console FIFO:
  - `tx_valid`/`tx_data` come from registered FIFO state; a pushed byte appears the cycle after acceptance.
  - A pop occurs when `tx_valid & tx_ready`.
  - Pointers wrap modulo `CONSOLE_DEPTH`; `count` is `$clog2(CONSOLE_DEPTH)+1` bits wide.
  - Simultaneous push and pop (not full) leaves `count` unchanged.
- Timeout: `done` rises at the clock edge where the counter equals `TIMEOUT_CYCLES`, i.e. `TIMEOUT_CYCLES` cycles after reset release.
- Reset values: `req_ready`=1 (combinational, FIFO empty); `rsp_valid`=0; `rsp_rdata`=0; `tx_valid`=0; `tx_data`=0; `done`=0; `pass`=0; `exit_code`=0; `timed_out`=0; FIFO empty; counter 0. Reset mid-transfer discards the pending response and all FIFO contents.

## Configuration
- `SIM_EXIT_CONSOLE_EN` defined: console FIFO and tx stream are present as described.
- `SIM_EXIT_CONSOLE_EN` undefined:
  - No FIFO is instantiated.
  - CONSOLE stores are accepted with `req_ready=1` and dropped.
  - `tx_valid`=0 and `tx_data`=0 constantly.
  - The STATUS count field reads 0.

## Structure
- Shared package `sim_exit_pkg`:
  - Offset constants `OFF_TOHOST`, `OFF_CONSOLE`, `OFF_STATUS`.
  - `TIMEOUT_EXIT_CODE`.
  - Typedef `sim_exit_status_t`, the packed STATUS layout.
- One sub-module, `sim_exit_fifo`: a parameterised synchronous FIFO with push/pop/full/empty/count and asynchronous active-high reset. It is instantiated only under `SIM_EXIT_CONSOLE_EN`.

## Test plan
- Store 32'h0000_0001 to BASE+0 → next cycle `done=1`, `pass=1`, `exit_code=0`; a later store of 32'h0000_000B is ignored.
- Store 32'h0000_0007 to BASE+0 → `done=1`, `pass=0`, `exit_code=3`; a load from BASE+0 returns 32'h0000_0007.
- With `tx_ready=0`, store bytes 0x48 and 0x69 to BASE+4, then `CONSOLE_DEPTH`-2 more → the next store sees `req_ready=0` until `tx_ready=1`. The stream then delivers 0x48 first and 0x69 second, and STATUS count reads 15 when the FIFO is full (16 entries, saturated).
- `TIMEOUT_CYCLES=50`, no stores → `done` rises 50 cycles after reset release with `timed_out=1`, `exit_code=31'h7FFF_FFFF` and `pass=0`.
- Load from BASE+0xC and from BASE+0x100 → `rsp_valid` one cycle later with `rsp_rdata=0`; state unchanged.
- Assert `arst` with 5 bytes queued and a response pending → all outputs return to reset values immediately, and `tx_valid` stays 0 after release.

Source files
------------

// File: rtl/sim_exit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sim_exit_pkg
//  Purpose  : Shared constants and types for the simulation-exit responder:
//             register-window offsets, the forced-timeout exit code and the
//             packed STATUS register layout.
//  Revision : 1.0  initial release
// ============================================================================
package sim_exit_pkg;

    // Word offsets inside the 16-byte register window.
    localparam logic [3:0] OFF_TOHOST  = 4'h0;
    localparam logic [3:0] OFF_CONSOLE = 4'h4;
    localparam logic [3:0] OFF_STATUS  = 4'h8;

    // Exit code reported when the cycle budget runs out.
    localparam logic [30:0] TIMEOUT_EXIT_CODE = 31'h7FFF_FFFF;

    // STATUS register: {27'b0, timed_out, count[3:0]}.
    typedef struct packed {
        logic [26:0] reserved;
        logic        timed_out;
        logic [3:0]  count;
    } sim_exit_status_t;

    // FIFO occupancy clipped to the 4-bit STATUS field.
    function automatic logic [3:0] sat_count4(input logic [31:0] cnt);
        return (cnt > 32'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sim_exit_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sim_exit_fifo
//  Purpose  : Parameterised synchronous FIFO with occupancy count.
//             Pushes while full and pops while empty are ignored.
//  Ports    : clk, arst (async, active-high)
//             push/push_data  - write side
//             pop/pop_data    - read side; pop_data is the head entry,
//                               0 while empty
//             full, empty, count ($clog2(DEPTH)+1 bits)
//  Revision : 1.0  initial release
// ============================================================================
module sim_exit_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    import sim_exit_pkg::*;

    localparam int                c_AW   = $clog2(DEPTH);
    localparam int                c_CW   = c_AW + 1;
    localparam logic [c_CW-1:0]   c_FULL = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == c_FULL);
    assign empty = (r_count == '0);
    assign count = r_count;

    // A push is refused while full even when a pop happens the same cycle.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop  & ~empty;

    // Gate the head so stale storage is never visible on an empty FIFO.
    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: it is only observed through the gated head.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/sim_exit_device.sv
`default_nettype none
// ============================================================================
//  Module   : sim_exit_device
//  Purpose  : Memory-mapped simulation-control responder. Decodes a 16-byte
//             register window at BASE_ADDR:
//               0x0 TOHOST  - sticky exit code / done flag
//               0x4 CONSOLE - byte pushed into the console FIFO
//               0x8 STATUS  - {27'b0, timed_out, count[3:0]}
//             and forces done after TIMEOUT_CYCLES cycles (0 disables).
//  Ports    : clk, arst (async, active-high)
//             req_*  - data-bus request (valid/ready)
//             rsp_*  - one-cycle-later response, registered read data
//             tx_*   - console byte stream (valid/ready)
//             done, pass, exit_code, timed_out - end-of-test status
//  Config   : SIM_EXIT_CONSOLE_EN - when defined the console FIFO and tx
//             stream exist; otherwise console stores are dropped, tx is
//             idle and the STATUS count reads 0.
//  Revision : 1.0  initial release
// ============================================================================
module sim_exit_device #(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int          CONSOLE_DEPTH  = 16,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        done,
    output logic        pass,
    output logic [30:0] exit_code,
    output logic        timed_out
);
    import sim_exit_pkg::*;

    localparam int          c_CNT_W   = $clog2(CONSOLE_DEPTH) + 1;
    localparam logic [31:0] c_TIMEOUT = 32'(TIMEOUT_CYCLES);

    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_done;
    logic               r_timed_out;
    logic [30:0]        r_exit_code;
    logic [31:0]        r_cycles;

    logic [3:0]         w_offset;
    logic               w_hit;
    logic               w_console_store;
    logic               w_accept;
    logic               w_push;
    logic               w_tohost_set;
    logic               w_timeout_hit;
    logic               w_fifo_full;
    logic [c_CNT_W-1:0] w_fifo_count;
    sim_exit_status_t   w_status;
    logic [31:0]        w_rdata;

    // Byte-address bits [1:0] are ignored; offsets are word-aligned.
    assign w_offset = {req_addr[3:2], 2'b00};
    assign w_hit    = (req_addr[31:4] == BASE_ADDR[31:4]);

    // Only a console store into a full FIFO is back-pressured.
    assign w_console_store = req_valid & req_we & w_hit & (w_offset == OFF_CONSOLE);
    assign req_ready       = ~(w_console_store & w_fifo_full);
    assign w_accept        = req_valid & req_ready;
    assign w_push          = w_accept & w_console_store & req_be[0];

    // Only the first qualifying TOHOST write counts; done is sticky.
    assign w_tohost_set = w_accept & req_we & w_hit & (w_offset == OFF_TOHOST)
                        & req_be[0] & req_wdata[0] & ~r_done;

    assign w_timeout_hit = (c_TIMEOUT != 32'd0) && ((r_cycles + 32'd1) == c_TIMEOUT);

    always_comb begin
        w_status           = '0;
        w_status.timed_out = r_timed_out;
        w_status.count     = sat_count4(32'(w_fifo_count));
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_offset)
                OFF_TOHOST: w_rdata = {r_exit_code, r_done};
                OFF_STATUS: w_rdata = w_status;
                default:    w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
            r_exit_code <= '0;
            r_cycles    <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_rdata <= (w_accept && !req_we) ? w_rdata : 32'd0;
            if (!r_done) begin
                r_cycles <= r_cycles + 32'd1;
                // A program exit in the same cycle as the timeout wins.
                if (w_tohost_set) begin
                    r_done      <= 1'b1;
                    r_exit_code <= req_wdata[31:1];
                    r_timed_out <= 1'b0;
                end else if (w_timeout_hit) begin
                    r_done      <= 1'b1;
                    r_exit_code <= TIMEOUT_EXIT_CODE;
                    r_timed_out <= 1'b1;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign done      = r_done;
    assign timed_out = r_timed_out;
    assign exit_code = r_exit_code;
    assign pass      = r_done & ~r_timed_out & (r_exit_code == 31'd0);

`ifdef SIM_EXIT_CONSOLE_EN
    logic       w_fifo_empty;
    logic [7:0] w_fifo_data;

    // The FIFO only pops when non-empty, so tx_ready alone is the pop request.
    sim_exit_fifo #(
        .DEPTH (CONSOLE_DEPTH),
        .WIDTH (8)
    ) u_console_fifo (
        .clk       (clk),
        .arst      (arst),
        .push      (w_push),
        .push_data (req_wdata[7:0]),
        .pop       (tx_ready),
        .pop_data  (w_fifo_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign tx_valid = ~w_fifo_empty;
    assign tx_data  = w_fifo_data;
`else
    logic w_unused_console;

    assign w_fifo_full      = 1'b0;
    assign w_fifo_count     = '0;
    assign tx_valid         = 1'b0;
    assign tx_data          = 8'h00;
    assign w_unused_console = &{1'b0, tx_ready, w_push};
`endif

    logic w_unused_bus;
    assign w_unused_bus = &{1'b0, req_be[3:1], req_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_sim_exit_device.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sim_exit_device
//  Purpose  : Self-checking bench for sim_exit_device. Bus responses and
//             console bytes are checked by a monitor against expectation
//             queues filled by the stimulus; status outputs are checked
//             directly. A second instance with TIMEOUT_CYCLES=50 covers
//             the forced timeout.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sim_exit_device;

    localparam logic [31:0] c_BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        arst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        tx_ready;
    wire         req_ready;
    wire         rsp_valid;
    wire [31:0]  rsp_rdata;
    wire         tx_valid;
    wire [7:0]   tx_data;
    wire         done;
    wire         pass;
    wire [30:0]  exit_code;
    wire         timed_out;

    // Timeout instance: bus idle, sink always ready.
    logic        to_zero = 1'b0;
    logic        to_one  = 1'b1;
    logic [31:0] to_zero32 = 32'd0;
    logic [3:0]  to_zero4  = 4'd0;
    wire         to_req_ready;
    wire         to_rsp_valid;
    wire [31:0]  to_rsp_rdata;
    wire         to_tx_valid;
    wire [7:0]   to_tx_data;
    wire         to_done;
    wire         to_pass;
    wire [30:0]  to_exit_code;
    wire         to_timed_out;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_rsp[$];
    logic [7:0]  exp_tx[$];

    always #5 clk = ~clk;

    sim_exit_device #(
        .BASE_ADDR      (c_BASE),
        .CONSOLE_DEPTH  (16),
        .TIMEOUT_CYCLES (0)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .done      (done),
        .pass      (pass),
        .exit_code (exit_code),
        .timed_out (timed_out)
    );

    sim_exit_device #(
        .BASE_ADDR      (c_BASE),
        .CONSOLE_DEPTH  (16),
        .TIMEOUT_CYCLES (50)
    ) dut_to (
        .clk       (clk),
        .arst      (arst),
        .req_valid (to_zero),
        .req_ready (to_req_ready),
        .req_we    (to_zero),
        .req_addr  (to_zero32),
        .req_wdata (to_zero32),
        .req_be    (to_zero4),
        .rsp_valid (to_rsp_valid),
        .rsp_rdata (to_rsp_rdata),
        .tx_valid  (to_tx_valid),
        .tx_data   (to_tx_data),
        .tx_ready  (to_one),
        .done      (to_done),
        .pass      (to_pass),
        .exit_code (to_exit_code),
        .timed_out (to_timed_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin : mon
        logic [31:0] e_rsp;
        logic [7:0]  e_tx;
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: rsp_valid=1 rdata=0x%08h, expected no response", rsp_rdata);
            end else begin
                e_rsp = exp_rsp.pop_front();
                chk("rsp_rdata", rsp_rdata, e_rsp);
            end
        end
        if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL tx_unexpected: byte 0x%02h delivered, expected none", tx_data);
            end else begin
                e_tx = exp_tx.pop_front();
                chk("tx_data", {24'd0, tx_data}, {24'd0, e_tx});
            end
        end
    end

    // Issue one request; returns 1 time unit after the accepting edge.
    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] rdata, input bit push_tx);
        int budget;
        budget    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(negedge clk);
        while (!req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL bus_ready_timeout: req_ready=0 after %0d cycles, expected 1", budget);
            req_valid = 1'b0;
        end else begin
            exp_rsp.push_back(rdata);
            if (push_tx) exp_tx.push_back(wdata[7:0]);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        arst      = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        tx_ready  = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
        chk("rst_status", {29'd0, done, pass, timed_out}, 32'd0);
        chk("rst_exit_code", {1'b0, exit_code}, 32'd0);

        // Timeout: done rises 50 edges after release.
        arst = 1'b0;
        repeat (49) @(posedge clk);
        #1 chk("to_done_early", {31'd0, to_done}, 32'd0);
        @(posedge clk);
        #1;
        chk("to_done", {31'd0, to_done}, 32'd1);
        chk("to_timed_out", {31'd0, to_timed_out}, 32'd1);
        chk("to_exit_code", {1'b0, to_exit_code}, 32'h7FFF_FFFF);
        chk("to_pass", {31'd0, to_pass}, 32'd0);
        chk("main_no_timeout", {31'd0, done}, 32'd0);

        // Unmapped offset and misses.
        bus(1'b0, c_BASE + 32'hC,   32'd0, 4'hF, 32'd0, 0);
        bus(1'b0, c_BASE + 32'h100, 32'd0, 4'hF, 32'd0, 0);
        bus(1'b1, c_BASE + 32'hC,   32'd1, 4'hF, 32'd0, 0);
        bus(1'b1, c_BASE + 32'h100, 32'd1, 4'hF, 32'd0, 0);
        bus(1'b1, c_BASE + 32'h10,  32'd1, 4'hF, 32'd0, 0);
        chk("miss_no_done", {31'd0, done}, 32'd0);
        // TOHOST stores that must be ignored: bit0 clear, be[0] clear.
        bus(1'b1, c_BASE, 32'h6, 4'hF, 32'd0, 0);
        bus(1'b1, c_BASE, 32'h7, 4'hE, 32'd0, 0);
        chk("tohost_ignored", {29'd0, done, pass, timed_out}, 32'd0);
        bus(1'b0, c_BASE + 32'h8, 32'd0, 4'hF, 32'd0, 0);

`ifdef SIM_EXIT_CONSOLE_EN
        // Fill the console FIFO with the sink stalled.
        bus(1'b1, c_BASE + 32'h4, 32'h48, 4'h1, 32'd0, 1);
        bus(1'b1, c_BASE + 32'h4, 32'h69, 4'h1, 32'd0, 1);
        for (int i = 0; i < 14; i++)
            bus(1'b1, c_BASE + 32'h4, 32'h30 + 32'(i), 4'h1, 32'd0, 1);
        bus(1'b0, c_BASE + 32'h8, 32'd0, 4'hF, 32'h0000_000F, 0);
        chk("full_tx_head", {23'd0, tx_valid, tx_data}, 32'h148);
        // Next console store stalls until a pop has made room.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = c_BASE + 32'h4;
        req_wdata = 32'h21;
        req_be    = 4'h1;
        @(negedge clk);
        chk("full_stall_a", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("full_stall_b", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 tx_ready = 1'b1;
        chk("stall_pop_cycle", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 chk("ready_after_pop", {31'd0, req_ready}, 32'd1);
        exp_rsp.push_back(32'd0);
        exp_tx.push_back(8'h21);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_tx.size() == 0) break;
        end
        @(posedge clk);
        #1;
        chk("tx_drained", {31'd0, tx_valid}, 32'd0);
        chk("tx_queue_left", 32'(exp_tx.size()), 32'd0);
        // be[0] clear: no push.
        bus(1'b1, c_BASE + 32'h4, 32'h55, 4'h2, 32'd0, 0);
        @(posedge clk);
        #1 chk("console_be0_clear", {31'd0, tx_valid}, 32'd0);
        bus(1'b0, c_BASE + 32'h8, 32'd0, 4'hF, 32'd0, 0);
`else
        // Console absent: stores accepted and dropped.
        for (int i = 0; i < 18; i++)
            bus(1'b1, c_BASE + 32'h4, 32'h41 + 32'(i), 4'h1, 32'd0, 0);
        chk("noconsole_tx", {23'd0, tx_valid, tx_data}, 32'd0);
        bus(1'b0, c_BASE + 32'h8, 32'd0, 4'hF, 32'd0, 0);
        tx_ready = 1'b1;
`endif

        // Passing exit.
        bus(1'b1, c_BASE, 32'h1, 4'hF, 32'd0, 0);
        chk("pass_flags", {29'd0, done, pass, timed_out}, 32'b110);
        chk("pass_exit_code", {1'b0, exit_code}, 32'd0);
        bus(1'b1, c_BASE, 32'hB, 4'hF, 32'd0, 0);
        chk("sticky_exit_code", {1'b0, exit_code}, 32'd0);
        chk("sticky_pass", {31'd0, pass}, 32'd1);
        bus(1'b0, c_BASE, 32'd0, 4'hF, 32'h1, 0);

        // Failing exit.
        pulse_reset();
        chk("reset_clears_done", {31'd0, done}, 32'd0);
        bus(1'b1, c_BASE, 32'h7, 4'h1, 32'd0, 0);
        chk("fail_flags", {29'd0, done, pass, timed_out}, 32'b100);
        chk("fail_exit_code", {1'b0, exit_code}, 32'd3);
        bus(1'b0, c_BASE,         32'd0, 4'hF, 32'h7, 0);
        bus(1'b0, c_BASE + 32'h1, 32'd0, 4'hF, 32'h7, 0);
        bus(1'b1, c_BASE, 32'h1, 4'hF, 32'd0, 0);
        chk("fail_sticky", {1'b0, exit_code}, 32'd3);

        // Reset with bytes queued and a response pending.
        @(posedge clk);
        #1 tx_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            bus(1'b1, c_BASE + 32'h4, 32'h60 + 32'(i), 4'h1, 32'd0, 0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = c_BASE + 32'h8;
        req_be    = 4'hF;
        @(negedge clk);
        @(posedge clk);
        #1;
        arst      = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("arst_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("arst_rdata", rsp_rdata, 32'd0);
        chk("arst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
        chk("arst_flags", {29'd0, done, pass, timed_out}, 32'd0);
        chk("arst_exit_code", {1'b0, exit_code}, 32'd0);
        chk("arst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        arst = 1'b0;
        #1 tx_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_arst_tx", {31'd0, tx_valid}, 32'd0);

        repeat (3) @(negedge clk);
        chk("rsp_queue_left", 32'(exp_rsp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
